// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Field positions follow the ARM data-processing encoding.
package fetch_pkg;

    localparam int WORD_W     = 32;
    localparam int WORD_BYTES = 4;

    localparam int COND_HI  = 31;
    localparam int COND_LO  = 28;
    localparam int OP_HI    = 27;
    localparam int OP_LO    = 26;
    localparam int FUNCT_HI = 25;
    localparam int FUNCT_LO = 20;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 12;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic [WORD_W-1:0] word_align(
        input logic [WORD_W-1:0] a
    );
        return {a[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched instructions with their PCs.
// Flush wins over push and pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push_i && !flush_i;
    assign pop_ok  = pop_i && (cnt_q != '0) && !flush_i;
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    // Pointer, occupancy and storage update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= entry_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_q <= rd_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // The credit scheme upstream must never let a push hit a full buffer
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push_ok && cnt_q == CW'(DEPTH)));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC generation, imem credit tracking,
// stale-response dropping on redirect and a decode-facing buffer.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus8,
    output logic [3:0]  out_cond,
    output logic [1:0]  out_op,
    output logic [5:0]  out_funct,
    output logic [3:0]  out_rd
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [OW-1:0] live_q, live_d;
    logic [OW-1:0] stale_q, stale_d;
    logic          running_q, running_d;

    logic          req_valid;
    logic          req_fire;
    logic          rsp_drop;
    logic          rsp_take;
    logic          rsp_any;
    logic          pop;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    // Credit check uses registered state only, so no comb path from decode
    always_comb begin
        req_valid = running_q
            && ((int'(live_q) + int'(stale_q)) < MAX_OUTSTANDING)
            && ((int'(live_q) + int'(fifo_count)) < DEPTH);
        req_fire  = req_valid && imem_req_ready;
        rsp_drop  = imem_rsp_valid && (stale_q != '0);
        rsp_take  = imem_rsp_valid && (stale_q == '0)
            && (live_q != '0);
        rsp_any   = rsp_drop || rsp_take;
        pop       = out_valid && out_ready;
        push_entry.instr = imem_rsp_data;
        push_entry.pc    = rsp_pc_q;
    end

    // Next-state for PCs and in-flight counters; redirect has priority
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        live_d     = live_q;
        stale_d    = stale_q;
        running_d  = 1'b1;
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_target);
            rsp_pc_d   = word_align(redirect_target);
            live_d     = '0;
            stale_d    = live_q + stale_q
                - OW'(rsp_any) + OW'(req_fire);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_take) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            live_d  = live_q + OW'(req_fire) - OW'(rsp_take);
            stale_d = stale_q - OW'(rsp_drop);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            live_q     <= '0;
            stale_q    <= '0;
            running_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            live_q     <= live_d;
            stale_q    <= stale_d;
            running_q  <= running_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .flush_i (redirect_valid),
        .push_i  (rsp_take),
        .entry_i (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (fifo_count)
    );

    // Decode-facing fields, forced to zero when the buffer is empty
    always_comb begin
        out_valid      = (fifo_count != '0);
        imem_req_valid = req_valid;
        imem_req_addr  = req_valid ? fetch_pc_q : '0;
        out_instr      = '0;
        out_pc         = '0;
        out_pc_plus8   = '0;
        if (out_valid) begin
            out_instr    = head.instr;
            out_pc       = head.pc;
            out_pc_plus8 = head.pc + 32'd8;
        end
        out_cond  = out_instr[COND_HI:COND_LO];
        out_op    = out_instr[OP_HI:OP_LO];
        out_funct = out_instr[FUNCT_HI:FUNCT_LO];
        out_rd    = out_instr[RD_HI:RD_LO];
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a random phase,
// checked against a sequential-stream scoreboard and an imem model.
module tb_instr_fetch_unit;

    localparam int          DEPTH   = 4;
    localparam int          MAX_OUT = 2;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus8;
    logic [3:0]  out_cond;
    logic [1:0]  out_op;
    logic [5:0]  out_funct;
    logic [3:0]  out_rd;

    instr_fetch_unit #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAX_OUT),
        .RESET_PC        (RST_PC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_pc_plus8    (out_pc_plus8),
        .out_cond        (out_cond),
        .out_op          (out_op),
        .out_funct       (out_funct),
        .out_rd          (out_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          acc;
    } req_t;

    req_t        mem_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          fires = 0;
    int          rdy_pct = 100;
    int          out_pct = 100;
    int          rsp_pct = 100;
    bit          rsp_en = 1'b1;
    bit          force_rsp = 1'b0;
    bit          drv_redir = 1'b0;
    logic [31:0] drv_tgt = '0;
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] exp_req = RST_PC;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hE3A0_1005 ^ (a * 32'h0100_0193);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Scoreboard: the decode stream must be consecutive words from the
    // last redirect target; requests likewise, within the credit limit.
    task automatic check_cycle(input logic rv);
        logic [31:0] w;
        if (prev_hold) begin
            chk("req_hold_valid", imem_req_valid, 1);
            chk("req_hold_addr", imem_req_addr, prev_addr);
        end
        prev_hold = imem_req_valid && !imem_req_ready && !redirect_valid;
        prev_addr = imem_req_addr;
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_req);
            chk("credit", 32'(mem_q.size() + int'(rv) < MAX_OUT), 1);
            mem_q.push_back('{addr: imem_req_addr, acc: cyc});
            exp_req = exp_req + 4;
            fires++;
        end
        if (out_valid) begin
            w = word(exp_pc);
            chk("out_pc", out_pc, exp_pc);
            chk("out_instr", out_instr, w);
            chk("out_pc_plus8", out_pc_plus8, exp_pc + 32'd8);
            chk("out_fields", {out_cond, out_op, out_funct, out_rd},
                {w[31:28], w[27:26], w[25:20], w[15:12]});
            if (out_ready && !redirect_valid) exp_pc = exp_pc + 4;
        end
        if (redirect_valid) begin
            exp_pc  = {redirect_target[31:2], 2'b00};
            exp_req = {redirect_target[31:2], 2'b00};
        end
    endtask

    task automatic step();
        logic        rv;
        logic [31:0] rd;
        rv = 1'b0;
        rd = '0;
        if (force_rsp) begin
            rv = 1'b1;
            rd = 32'hDEAD_BEEF;
            force_rsp = 1'b0;
        end else if (rsp_en && mem_q.size() > 0 && mem_q[0].acc < cyc
                     && $urandom_range(99) < rsp_pct) begin
            rv = 1'b1;
            rd = word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        imem_rsp_valid  = rv;
        imem_rsp_data   = rd;
        imem_req_ready  = ($urandom_range(99) < rdy_pct);
        out_ready       = ($urandom_range(99) < out_pct);
        redirect_valid  = drv_redir;
        redirect_target = drv_tgt;
        @(negedge clk);
        if (reset) check_cycle(rv);
        @(posedge clk);
        #1;
        cyc++;
        drv_redir = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int f0;
        reset           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = '0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        out_ready       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valids", {30'b0, out_valid, imem_req_valid}, 0);
        chk("rst_addr", imem_req_addr, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_plus8", out_pc_plus8, 0);
        chk("rst_instr", out_instr, 0);

        // Release: one idle cycle, then streaming at 1 instr/cycle
        reset = 1'b1;
        chk("run_delay", imem_req_valid, 0);
        step();
        chk("first_req_v", imem_req_valid, 1);
        chk("first_addr", imem_req_addr, RST_PC);
        step();
        chk("lat_t1", out_valid, 0);
        step();
        chk("lat_t2", out_valid, 1);
        chk("pc0", out_pc, 0);
        chk("plus8_0", out_pc_plus8, 8);
        chk("cond", out_cond, 4'hE);
        chk("op", out_op, 2'h0);
        chk("funct", out_funct, 6'h3A);
        chk("rd", out_rd, 4'h1);
        repeat (6) begin
            step();
            chk("stream", out_valid, 1);
        end

        // Backpressure fills exactly DEPTH entries and stops fetch
        out_pct = 0;
        repeat (12) step();
        chk("bp_reqv", imem_req_valid, 0);
        chk("bp_valid", out_valid, 1);
        rdy_pct = 0;
        out_pct = 100;
        n = 0;
        repeat (6) begin
            n += int'(out_valid);
            step();
        end
        chk("bp_drain", n, DEPTH);
        chk("bp_empty", out_valid, 0);
        rdy_pct = 100;
        f0 = fires;
        repeat (3) step();
        chk("bp_resume", 32'(fires > f0), 1);

        // Redirect with two requests in flight
        rsp_en = 1'b0;
        k = 0;
        while (mem_q.size() < MAX_OUT && k < 10) begin
            step();
            k++;
        end
        chk("inflight", mem_q.size(), MAX_OUT);
        chk("credit_stop", imem_req_valid, 0);
        drv_redir = 1'b1;
        drv_tgt   = 32'h0000_0103;
        step();
        chk("redir_flush", out_valid, 0);
        rsp_en = 1'b1;
        k = 0;
        while (!out_valid && k < 10) begin
            step();
            k++;
        end
        chk("redir_pc", out_pc, 32'h0000_0100);

        // Redirect in the same cycle as a request fire and a pop
        repeat (4) step();
        chk("both_busy", 32'(imem_req_valid && out_valid), 1);
        drv_redir = 1'b1;
        drv_tgt   = 32'h0000_0200;
        step();
        chk("sc_flush", out_valid, 0);
        k = 0;
        while (!out_valid && k < 10) begin
            step();
            k++;
        end
        chk("sc_pc", out_pc, 32'h0000_0200);

        // PC wrap across 2^32
        drv_redir = 1'b1;
        drv_tgt   = 32'hFFFF_FFF6;
        step();
        repeat (8) step();

        // Random traffic with occasional redirects
        rdy_pct = 70;
        out_pct = 60;
        rsp_pct = 60;
        repeat (600) begin
            if ($urandom_range(99) < 4) begin
                drv_redir = 1'b1;
                drv_tgt   = $urandom();
            end
            step();
        end
        rdy_pct = 100;
        out_pct = 100;
        rsp_pct = 100;
        repeat (10) step();
        chk("live_end", out_valid, 1);

        // Asynchronous reset with a response still pending
        rsp_en = 1'b0;
        step();
        chk("pend", 32'(mem_q.size() > 0), 1);
        chk("pend_valid", out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_valids", {30'b0, out_valid, imem_req_valid}, 0);
        chk("mid_pc", out_pc, 0);
        chk("mid_instr", out_instr, 0);
        chk("mid_addr", imem_req_addr, 0);
        mem_q.delete();
        exp_pc    = RST_PC;
        exp_req   = RST_PC;
        prev_hold = 1'b0;
        rsp_en    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        force_rsp = 1'b1;
        step();
        chk("ign_stale", out_valid, 0);
        chk("rr_req_v", imem_req_valid, 1);
        chk("rr_addr", imem_req_addr, RST_PC);
        step();
        chk("ign_stale2", out_valid, 0);
        step();
        chk("rr_valid", out_valid, 1);
        chk("rr_pc", out_pc, RST_PC);
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
